mem_port2_arbiter: RTL and testbench
====================================

// Module: mem_port2_arbiter
// PURPOSE
//  Arbitrates memory port 2 between the CPU (requester 0) and the serial programmer (requester 1).
//  Fixed priority to the programmer, with bus lock across bursts and an idle handover gap on every
//  ownership change. Issues a CPU reset pulse after a programming session that wrote memory.
//  Watchdog releases a stuck lock. Sits between CPU/programmer and the OTTER memory port 2.
// PARAMETERS
//  ADDR_W        32     address width
//  DATA_W        32     write-data width
//  HANDOVER_CYC  1      idle cycles inserted on CPU->programmer switch (>=1)
//  LOCK_TIMEOUT  65535  max consecutive locked-idle cycles in PRG_OWN; 0 disables watchdog
//  RST_PULSE     2      cpu_rst high time in cycles (>=1)
// PORTS
//  CLK        in   1       clock, rising edge
//  RST        in   1       asynchronous, active-high reset
//  cpu_req    in   1       CPU port-2 access this cycle
//  cpu_we     in   1       1=write, 0=read
//  cpu_addr   in   ADDR_W  CPU address
//  cpu_din    in   DATA_W  CPU write data
//  cpu_size   in   2       CPU access size
//  cpu_sign   in   1       CPU load sign-extend
//  cpu_stall  out  1       CPU must hold its request
//  cpu_rst    out  1       CPU reset pulse after a dirty programming session
//  prg_req    in   1       programmer access this cycle
//  prg_lock   in   1       programmer keeps ownership between accesses
//  prg_we     in   1       1=write, 0=read
//  prg_addr   in   ADDR_W  programmer address
//  prg_din    in   DATA_W  programmer write data
//  prg_size   in   2       programmer access size
//  prg_sign   in   1       programmer sign
//  prg_gnt    out  1       programmer owns port; access counts when prg_req & prg_gnt
//  mem_read2  out  1       to memory
//  mem_write  out  1       to memory
//  mem_addr2  out  ADDR_W  to memory
//  mem_din2   out  DATA_W  to memory
//  mem_size   out  2       to memory
//  mem_sign   out  1       to memory
//  owner      out  1       0=CPU, 1=programmer (state==PRG_OWN)
//  timeout    out  1       sticky watchdog flag
// BEHAVIOUR
//  - States: CPU_OWN, HANDOVER, PRG_OWN, RELEASE. Reset -> CPU_OWN; counters=0; dirty=0; timeout=0.
//  - Outputs are combinational from state and inputs.
//    During reset: cpu_stall=0, cpu_rst=0, prg_gnt=0, owner=0, mem_* follow CPU as in CPU_OWN.
//  - CPU_OWN:
//    mem_* = cpu_* with mem_write=cpu_req&cpu_we and mem_read2=cpu_req&~cpu_we; cpu_stall=0.
//    prg_req=1 -> HANDOVER. Any CPU access presented in that same cycle is completed that cycle.
//  - HANDOVER: mem_read2=mem_write=0; cpu_stall=cpu_req.
//    Counter runs HANDOVER_CYC cycles, then -> PRG_OWN.
//    prg_req drops before expiry -> CPU_OWN, counter cleared.
//  - PRG_OWN: prg_gnt=1; mem_* = prg_* with mem_write=prg_req&prg_we and mem_read2=prg_req&~prg_we.
//    cpu_stall=cpu_req. A granted write sets dirty.
//    prg_req=0 & prg_lock=0 -> RELEASE if dirty, else CPU_OWN.
//  - Watchdog: counts consecutive PRG_OWN cycles with prg_lock=1 & prg_req=0; prg_req=1 clears it.
//    Count reaching LOCK_TIMEOUT sets timeout=1 and forces -> RELEASE if dirty, else CPU_OWN.
//    timeout stays set until the next entry to PRG_OWN (or RST).
//  - RELEASE: cpu_rst=1; cpu_stall=1; mem_read2=mem_write=0. Lasts RST_PULSE cycles, then -> CPU_OWN.
//    dirty clears on exit. prg_req is ignored until CPU_OWN is reached.
//  - Counters saturate; they never wrap.
//  - RST asserted mid-session: immediate CPU_OWN; the session is abandoned with no cpu_rst pulse.
// TESTING
//  1 Reset with cpu_req=1, cpu_we=1, cpu_addr=0x100 -> mem_write=1, mem_addr2=0x100, cpu_stall=0.
//  2 prg_req rises at cycle t with cpu_req=1: CPU access done at t; HANDOVER at t+1 (mem idle);
//    prg_gnt=1 at t+2; cpu_stall=1 from t+1.
//  3 Burst of 4 locked writes to 0..3 (data 0x11..0x44), then prg_req=prg_lock=0:
//    4 mem_write pulses; cpu_rst=1 for exactly 2 cycles; then owner=0.
//  4 Read-only session (prg_we=0), then release -> returns to CPU_OWN with no cpu_rst pulse.
//  5 LOCK_TIMEOUT=8, prg_lock held with prg_req=0 after 1 write ->
//    timeout=1 after 8 idle cycles, RELEASE then CPU_OWN.
//  6 RST asserted while in PRG_OWN -> owner=0, prg_gnt=0 and cpu_rst=0 immediately (async).

Source files
------------

// File: rtl/mem_port2_arbiter.sv
// Memory port 2 arbiter: CPU vs. serial programmer. The programmer has fixed priority and can
// lock the bus across bursts. The CPU is reset after any session that wrote memory.
module mem_port2_arbiter #(
  parameter int ADDR_W       = 32,
  parameter int DATA_W       = 32,
  parameter int HANDOVER_CYC = 1,
  parameter int LOCK_TIMEOUT = 65535,
  parameter int RST_PULSE    = 2
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_din,
  input  logic [1:0]        cpu_size,
  input  logic              cpu_sign,
  output logic              cpu_stall,
  output logic              cpu_rst,
  input  logic              prg_req,
  input  logic              prg_lock,
  input  logic              prg_we,
  input  logic [ADDR_W-1:0] prg_addr,
  input  logic [DATA_W-1:0] prg_din,
  input  logic [1:0]        prg_size,
  input  logic              prg_sign,
  output logic              prg_gnt,
  output logic              mem_read2,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr2,
  output logic [DATA_W-1:0] mem_din2,
  output logic [1:0]        mem_size,
  output logic              mem_sign,
  output logic              owner,
  output logic              timeout
);

  localparam int HC_W = (HANDOVER_CYC > 1) ? $clog2(HANDOVER_CYC + 1) : 1;
  localparam int WD_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT + 1) : 1;
  localparam int RP_W = (RST_PULSE > 1)    ? $clog2(RST_PULSE + 1)    : 1;
  localparam logic [HC_W:0] HC_LIM = (HC_W + 1)'(HANDOVER_CYC);
  localparam logic [WD_W:0] WD_LIM = (WD_W + 1)'(LOCK_TIMEOUT);
  localparam logic [RP_W:0] RP_LIM = (RP_W + 1)'(RST_PULSE);

  typedef enum logic [1:0] {CPU_OWN, HANDOVER, PRG_OWN, RELEASE} state_e;

  state_e          state_q, state_d;
  logic [HC_W-1:0] hcnt_q, hcnt_d;
  logic [WD_W-1:0] wd_q, wd_d;
  logic [RP_W-1:0] rcnt_q, rcnt_d;
  logic            dirty_q, dirty_d;
  logic            timeout_q, timeout_d;

  logic [HC_W:0] hinc;
  logic [WD_W:0] winc;
  logic [RP_W:0] rinc;

  assign hinc = {1'b0, hcnt_q} + (HC_W + 1)'(1);
  assign winc = {1'b0, wd_q}   + (WD_W + 1)'(1);
  assign rinc = {1'b0, rcnt_q} + (RP_W + 1)'(1);

  always_comb begin
    state_d   = state_q;
    hcnt_d    = hcnt_q;
    wd_d      = wd_q;
    rcnt_d    = rcnt_q;
    dirty_d   = dirty_q;
    timeout_d = timeout_q;
    case (state_q)
      CPU_OWN: begin
        hcnt_d = '0;
        if (prg_req) state_d = HANDOVER;
      end
      HANDOVER: begin
        if (!prg_req) begin
          state_d = CPU_OWN;
          hcnt_d  = '0;
        end else if (hinc >= HC_LIM) begin
          state_d   = PRG_OWN;
          hcnt_d    = '0;
          wd_d      = '0;
          timeout_d = 1'b0;
        end else begin
          hcnt_d = hinc[HC_W-1:0];
        end
      end
      PRG_OWN: begin
        if (prg_req && prg_we) dirty_d = 1'b1;
        if (prg_req) begin
          wd_d = '0;
        end else if (!prg_lock) begin
          state_d = dirty_q ? RELEASE : CPU_OWN;
          wd_d    = '0;
        end else if (LOCK_TIMEOUT != 0 && winc == WD_LIM) begin
          // Locked but idle for too long: assume the programmer died mid-session.
          state_d   = dirty_q ? RELEASE : CPU_OWN;
          wd_d      = '0;
          timeout_d = 1'b1;
        end else if (wd_q != '1) begin
          wd_d = winc[WD_W-1:0];
        end
      end
      RELEASE: begin
        if (rinc >= RP_LIM) begin
          state_d = CPU_OWN;
          rcnt_d  = '0;
          dirty_d = 1'b0;
        end else begin
          rcnt_d = rinc[RP_W-1:0];
        end
      end
      default: state_d = CPU_OWN;
    endcase
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q   <= CPU_OWN;
      hcnt_q    <= '0;
      wd_q      <= '0;
      rcnt_q    <= '0;
      dirty_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      hcnt_q    <= hcnt_d;
      wd_q      <= wd_d;
      rcnt_q    <= rcnt_d;
      dirty_q   <= dirty_d;
      timeout_q <= timeout_d;
    end
  end

  // Data path follows the CPU except while the programmer owns the port.
  always_comb begin
    mem_addr2 = cpu_addr;
    mem_din2  = cpu_din;
    mem_size  = cpu_size;
    mem_sign  = cpu_sign;
    mem_write = 1'b0;
    mem_read2 = 1'b0;
    cpu_stall = 1'b0;
    cpu_rst   = 1'b0;
    prg_gnt   = 1'b0;
    case (state_q)
      CPU_OWN: begin
        mem_write = cpu_req & cpu_we;
        mem_read2 = cpu_req & ~cpu_we;
      end
      HANDOVER: cpu_stall = cpu_req;
      PRG_OWN: begin
        prg_gnt   = 1'b1;
        cpu_stall = cpu_req;
        mem_addr2 = prg_addr;
        mem_din2  = prg_din;
        mem_size  = prg_size;
        mem_sign  = prg_sign;
        mem_write = prg_req & prg_we;
        mem_read2 = prg_req & ~prg_we;
      end
      RELEASE: begin
        cpu_rst   = 1'b1;
        cpu_stall = 1'b1;
      end
      default: ;
    endcase
  end

  assign owner   = (state_q == PRG_OWN);
  assign timeout = timeout_q;

endmodule

// File: tb/tb_mem_port2_arbiter.sv
// Directed bench for mem_port2_arbiter: handover timing, dirty/clean sessions, watchdog, async reset.
module tb_mem_port2_arbiter;
  logic        CLK = 1'b0;
  logic        RST;
  logic        cpu_req, cpu_we, cpu_sign, prg_req, prg_lock, prg_we, prg_sign;
  logic [31:0] cpu_addr, cpu_din, prg_addr, prg_din;
  logic [1:0]  cpu_size, prg_size;
  logic        cpu_stall, cpu_rst, prg_gnt, mem_read2, mem_write, mem_sign, owner, timeout;
  logic [31:0] mem_addr2, mem_din2;
  logic [1:0]  mem_size;

  int checks = 0;
  int fails  = 0;
  int wcnt   = 0;
  int rc;

  mem_port2_arbiter #(
    .ADDR_W(32), .DATA_W(32), .HANDOVER_CYC(1), .LOCK_TIMEOUT(8), .RST_PULSE(2)
  ) dut (
    .CLK(CLK), .RST(RST),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
    .cpu_size(cpu_size), .cpu_sign(cpu_sign), .cpu_stall(cpu_stall), .cpu_rst(cpu_rst),
    .prg_req(prg_req), .prg_lock(prg_lock), .prg_we(prg_we), .prg_addr(prg_addr),
    .prg_din(prg_din), .prg_size(prg_size), .prg_sign(prg_sign), .prg_gnt(prg_gnt),
    .mem_read2(mem_read2), .mem_write(mem_write), .mem_addr2(mem_addr2), .mem_din2(mem_din2),
    .mem_size(mem_size), .mem_sign(mem_sign), .owner(owner), .timeout(timeout)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) if (mem_write && prg_gnt) wcnt++;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 2 units later.
  task automatic nxt();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    RST = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_din = 32'hAB; cpu_size = 2'd2; cpu_sign = 1'b0;
    prg_req = 1'b0; prg_lock = 1'b0; prg_we = 1'b0; prg_addr = 32'h0; prg_din = 32'h0;
    prg_size = 2'd2; prg_sign = 1'b1;
    #3;
    chk("rst_mem_write", 32'(mem_write), 32'd1);
    chk("rst_mem_addr",  mem_addr2, 32'h100);
    chk("rst_stall",     32'(cpu_stall), 32'd0);
    chk("rst_owner",     32'(owner), 32'd0);
    chk("rst_gnt",       32'(prg_gnt), 32'd0);
    chk("rst_cpu_rst",   32'(cpu_rst), 32'd0);
    chk("rst_timeout",   32'(timeout), 32'd0);
    nxt(); RST = 1'b0;

    // Programmer request collides with a CPU read; clean session
    nxt(); cpu_we = 1'b0; cpu_addr = 32'h200;
    prg_req = 1'b1; prg_we = 1'b0; prg_addr = 32'h80; #2;
    chk("t_cpu_read", 32'(mem_read2), 32'd1);
    chk("t_addr",     mem_addr2, 32'h200);
    chk("t_stall",    32'(cpu_stall), 32'd0);
    nxt(); #2;
    chk("t1_idle_rd", 32'(mem_read2), 32'd0);
    chk("t1_idle_wr", 32'(mem_write), 32'd0);
    chk("t1_stall",   32'(cpu_stall), 32'd1);
    chk("t1_gnt",     32'(prg_gnt), 32'd0);
    nxt(); #2;
    chk("t2_gnt",     32'(prg_gnt), 32'd1);
    chk("t2_owner",   32'(owner), 32'd1);
    chk("t2_stall",   32'(cpu_stall), 32'd1);
    chk("t2_read",    32'(mem_read2), 32'd1);
    chk("t2_addr",    mem_addr2, 32'h80);
    chk("t2_sign",    32'(mem_sign), 32'd1);
    nxt(); prg_req = 1'b0; #2;
    chk("clean_last_own", 32'(owner), 32'd1);
    nxt(); #2;
    chk("clean_owner", 32'(owner), 32'd0);
    chk("clean_rst",   32'(cpu_rst), 32'd0);
    chk("clean_stall", 32'(cpu_stall), 32'd0);

    // Programmer withdraws during handover
    nxt(); prg_req = 1'b1;
    nxt(); prg_req = 1'b0; #2;
    chk("abort_ho_stall", 32'(cpu_stall), 32'd1);
    nxt(); #2;
    chk("abort_stall", 32'(cpu_stall), 32'd0);
    chk("abort_owner", 32'(owner), 32'd0);
    nxt(); #2;
    chk("abort_gnt", 32'(prg_gnt), 32'd0);

    // Locked 4-write burst, dirty release
    wcnt = 0;
    nxt(); prg_req = 1'b1; prg_lock = 1'b1; prg_we = 1'b1; prg_addr = 32'd0; prg_din = 32'h11;
    nxt();
    for (int i = 0; i < 4; i++) begin
      nxt(); prg_addr = 32'(i); prg_din = 32'h11 * (i + 1); #2;
      chk("burst_addr", mem_addr2, 32'(i));
      chk("burst_din",  mem_din2, 32'h11 * (i + 1));
    end
    nxt(); prg_req = 1'b0; prg_lock = 1'b0;
    rc = 0;
    for (int i = 0; i < 6; i++) begin
      nxt(); #2;
      if (cpu_rst) rc++;
    end
    chk("burst_writes", 32'(wcnt), 32'd4);
    chk("burst_rst_len", 32'(rc), 32'd2);
    chk("burst_owner", 32'(owner), 32'd0);

    // Watchdog: one write, then locked idle
    nxt(); prg_req = 1'b1; prg_lock = 1'b1; prg_we = 1'b1; prg_addr = 32'h40;
    nxt();
    nxt(); #2;
    chk("wd_write", 32'(mem_write), 32'd1);
    nxt(); prg_req = 1'b0;
    for (int i = 0; i < 8; i++) begin
      #2;
      chk("wd_hold_owner", 32'(owner), 32'd1);
      chk("wd_hold_to",    32'(timeout), 32'd0);
      nxt();
    end
    #2;
    chk("wd_timeout", 32'(timeout), 32'd1);
    chk("wd_rel_rst", 32'(cpu_rst), 32'd1);
    chk("wd_rel_own", 32'(owner), 32'd0);
    prg_lock = 1'b0;
    nxt(); #2;
    chk("wd_rel_rst2", 32'(cpu_rst), 32'd1);
    nxt(); #2;
    chk("wd_done_rst", 32'(cpu_rst), 32'd0);
    chk("wd_sticky",   32'(timeout), 32'd1);

    // Async reset mid-session
    nxt(); prg_req = 1'b1; prg_lock = 1'b1;
    nxt();
    nxt(); #2;
    chk("ar_owner_pre", 32'(owner), 32'd1);
    chk("ar_to_clear",  32'(timeout), 32'd0);
    RST = 1'b1; #1;
    chk("ar_owner", 32'(owner), 32'd0);
    chk("ar_gnt",   32'(prg_gnt), 32'd0);
    chk("ar_rst",   32'(cpu_rst), 32'd0);
    prg_req = 1'b0; prg_lock = 1'b0;
    nxt(); RST = 1'b0;
    nxt(); #2;
    chk("ar_post_rst", 32'(cpu_rst), 32'd0);
    chk("ar_post_own", 32'(owner), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
